// File: rtl/register_unit_param.sv
// register_unit_param: general-register file with paired address-bus views, pair increment,
// registered data/address bus drives and a sticky control-conflict flag.
module register_unit_param #(
  parameter int W         = 8,
  parameter int NREG      = 8,
  parameter int PAIR_BASE = 4,
  parameter int NPAIR     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREG-1:0]    ld,
  input  logic [NREG-1:0]    sel,
  input  logic [NPAIR-1:0]   ld_pair,
  input  logic [NPAIR-1:0]   sel_pair,
  input  logic [NPAIR-1:0]   inc_pair,
  input  logic [W-1:0]       data_in,
  input  logic [2*W-1:0]     addr_in,
  input  logic               clr_err,
  output logic [W-1:0]       data_out,
  output logic               data_vld,
  output logic [2*W-1:0]     addr_out,
  output logic               addr_vld,
  output logic               conflict
);
  logic [W-1:0]   r_reg [NREG];
  logic [W-1:0]   w_nxt [NREG];
  logic [NREG-1:0] w_wc;
  logic [2*W-1:0] w_pv   [NPAIR];
  logic [2*W-1:0] w_pinc [NPAIR];
  logic [W-1:0]   w_dmux;
  logic [2*W-1:0] w_amux;
  logic           w_conf;
  genvar p, g;
  for (p = 0; p < NPAIR; p++) begin : g_pv
    assign w_pv[p]   = {r_reg[PAIR_BASE+2*p], r_reg[PAIR_BASE+2*p+1]};
    assign w_pinc[p] = w_pv[p] + (2*W)'(1);
  end
  // Per-register next value with priority ld_pair > ld > inc_pair
  for (g = 0; g < NREG; g++) begin : g_reg
    if (g >= PAIR_BASE && g < PAIR_BASE + 2*NPAIR) begin : g_pair
      localparam int P  = (g - PAIR_BASE) / 2;
      localparam bit HI = ((g - PAIR_BASE) % 2) == 0;
      logic [W-1:0] w_ldv, w_incv;
      assign w_ldv    = HI ? addr_in[2*W-1:W] : addr_in[W-1:0];
      assign w_incv   = HI ? w_pinc[P][2*W-1:W] : w_pinc[P][W-1:0];
      assign w_nxt[g] = ld_pair[P] ? w_ldv : ld[g] ? data_in : inc_pair[P] ? w_incv : r_reg[g];
      assign w_wc[g]  = (ld_pair[P] & ld[g]) | (ld_pair[P] & inc_pair[P]) | (ld[g] & inc_pair[P]);
    end else begin : g_solo
      assign w_nxt[g] = ld[g] ? data_in : r_reg[g];
      assign w_wc[g]  = 1'b0;
    end
  end
  always_comb begin
    w_dmux = '0;
    w_amux = '0;
    for (int i = 0; i < NREG; i++) w_dmux = w_dmux | (r_reg[i] & {W{sel[i]}});
    for (int i = 0; i < NPAIR; i++) w_amux = w_amux | (w_pv[i] & {(2*W){sel_pair[i]}});
  end
  assign w_conf = (|w_wc) || ($countones(sel) > 1) || ($countones(sel_pair) > 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_reg[i] <= '0;
      data_out <= '0;
      data_vld <= 1'b0;
      addr_out <= '0;
      addr_vld <= 1'b0;
      conflict <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) r_reg[i] <= w_nxt[i];
      data_vld <= $onehot(sel);
      data_out <= $onehot(sel) ? w_dmux : '0;
      addr_vld <= $onehot(sel_pair);
      addr_out <= $onehot(sel_pair) ? w_amux : '0;
      conflict <= w_conf | (conflict & ~clr_err);
    end
  end
endmodule
